float_adder: RTL

//  IEEE-754 single-precision adder, z = a + b, round-to-nearest-even.

---
 rtl/float_adder_if.sv | 34 +++
 rtl/float_adder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_if.sv
// float_adder_if -- stb/ack handshake bundle for the single-precision adder.
`default_nettype none

interface float_adder_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport slave (
    input  input_a, input_a_stb,
    output input_a_ack,
    input  input_b, input_b_stb,
    output input_b_ack,
    output output_z, output_z_stb,
    input  output_z_ack
  );

  modport master (
    output input_a, input_a_stb,
    input  input_a_ack,
    output input_b, input_b_stb,
    input  input_b_ack,
    input  output_z, output_z_stb,
    output output_z_ack
  );
endinterface

`default_nettype wire

// File: rtl/float_adder.sv
// float_adder -- IEEE-754 single-precision z = a + b, round-to-nearest-even,
// multi-cycle FSM with stb/ack handshakes on a, b and z. Rev 1.0
`default_nettype none

module float_adder (
  input  logic          clk,
  input  logic          rst,
  float_adder_if.slave  bus_io
);

  localparam logic [3:0] GET_A         = 4'd0;
  localparam logic [3:0] GET_B         = 4'd1;
  localparam logic [3:0] UNPACK        = 4'd2;
  localparam logic [3:0] SPECIAL_CASES = 4'd3;
  localparam logic [3:0] ALIGN         = 4'd4;
  localparam logic [3:0] ADD_0         = 4'd5;
  localparam logic [3:0] ADD_1         = 4'd6;
  localparam logic [3:0] NORMALISE_1   = 4'd7;
  localparam logic [3:0] NORMALISE_2   = 4'd8;
  localparam logic [3:0] ROUND         = 4'd9;
  localparam logic [3:0] PACK          = 4'd10;
  localparam logic [3:0] PUT_Z         = 4'd11;

  localparam logic [31:0]       QNAN   = 32'hFFC0_0000;
  localparam logic signed [9:0] E_INF  = 10'sd128;
  localparam logic signed [9:0] E_ZERO = -10'sd127;
  localparam logic signed [9:0] E_MIN  = -10'sd126;
  localparam logic signed [9:0] E_MAX  = 10'sd127;

  logic [3:0]        state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d, z_q, z_d;
  logic [26:0]       a_m_q, a_m_d, b_m_q, b_m_d;
  logic [23:0]       z_m_q, z_m_d;
  logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic              a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic              guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [27:0]       sum_q, sum_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  logic a_is_nan, b_is_nan, a_is_inf, b_is_inf, a_is_zero, b_is_zero;

  assign a_is_nan  = (a_e_q == E_INF)  && (a_m_q != 27'd0);
  assign b_is_nan  = (b_e_q == E_INF)  && (b_m_q != 27'd0);
  assign a_is_inf  = (a_e_q == E_INF)  && (a_m_q == 27'd0);
  assign b_is_inf  = (b_e_q == E_INF)  && (b_m_q == 27'd0);
  assign a_is_zero = (a_e_q == E_ZERO) && (a_m_q == 27'd0);
  assign b_is_zero = (b_e_q == E_ZERO) && (b_m_q == 27'd0);

  assign bus_io.input_a_ack  = a_ack_q;
  assign bus_io.input_b_ack  = b_ack_q;
  assign bus_io.output_z     = z_q;
  assign bus_io.output_z_stb = z_stb_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    z_m_d    = z_m_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    z_e_d    = z_e_q;
    a_s_d    = a_s_q;
    b_s_d    = b_s_q;
    z_s_d    = z_s_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    a_ack_d  = a_ack_q;
    b_ack_d  = b_ack_q;
    z_stb_d  = z_stb_q;

    case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && bus_io.input_a_stb) begin
          a_d     = bus_io.input_a;
          a_ack_d = 1'b0;
          state_d = GET_B;
        end
      end

      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && bus_io.input_b_stb) begin
          b_d     = bus_io.input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        a_m_d   = {a_q[22:0], 3'b000};
        b_m_d   = {b_q[22:0], 3'b000};
        a_e_d   = {2'b00, a_q[30:23]} - 10'd127;
        b_e_d   = {2'b00, b_q[30:23]} - 10'd127;
        a_s_d   = a_q[31];
        b_s_d   = b_q[31];
        state_d = SPECIAL_CASES;
      end

      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (a_is_nan || b_is_nan || (a_is_inf && b_is_inf && (a_s_q != b_s_q))) begin
          z_d = QNAN;
        end else if (a_is_inf) begin
          z_d = {a_s_q, 8'hFF, 23'd0};
        end else if (b_is_inf) begin
          z_d = {b_s_q, 8'hFF, 23'd0};
        end else if (a_is_zero && b_is_zero) begin
          z_d = {a_s_q & b_s_q, 31'd0};
        end else if (a_is_zero) begin
          z_d = b_q;
        end else if (b_is_zero) begin
          z_d = a_q;
        end else begin
          state_d = ALIGN;
          // Denormals keep hidden=0 and take the minimum normal exponent.
          if (a_e_q == E_ZERO) a_e_d = E_MIN;
          else                 a_m_d[26] = 1'b1;
          if (b_e_q == E_ZERO) b_e_d = E_MIN;
          else                 b_m_d[26] = 1'b1;
        end
      end

      ALIGN: begin
        if (a_e_q > b_e_q) begin
          b_e_d = b_e_q + 10'sd1;
          b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
        end else if (a_e_q < b_e_q) begin
          a_e_d = a_e_q + 10'sd1;
          a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
        end else begin
          state_d = ADD_0;
        end
      end

      ADD_0: begin
        state_d = ADD_1;
        z_e_d   = a_e_q;
        if (a_s_q == b_s_q) begin
          sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else if (a_m_q == b_m_q) begin
          // Exact cancellation: park the exponent at the denormal floor so
          // pack emits +0 without any normalisation steps.
          sum_d = 28'd0;
          z_s_d = 1'b0;
          z_e_d = E_MIN;
        end else if (a_m_q > b_m_q) begin
          sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else begin
          sum_d = {1'b0, b_m_q} - {1'b0, a_m_q};
          z_s_d = b_s_q;
        end
      end

      ADD_1: begin
        state_d = NORMALISE_1;
        if (sum_q[27]) begin
          z_m_d    = sum_q[27:4];
          guard_d  = sum_q[3];
          round_d  = sum_q[2];
          sticky_d = sum_q[1] | sum_q[0];
          z_e_d    = z_e_q + 10'sd1;
        end else begin
          z_m_d    = sum_q[26:3];
          guard_d  = sum_q[2];
          round_d  = sum_q[1];
          sticky_d = sum_q[0];
        end
      end

      NORMALISE_1: begin
        if (!z_m_q[23] && (z_e_q > E_MIN) && (sum_q != 28'd0)) begin
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
          z_e_d   = z_e_q - 10'sd1;
        end else begin
          state_d = NORMALISE_2;
        end
      end

      NORMALISE_2: begin
        if (z_e_q < E_MIN) begin
          z_e_d    = z_e_q + 10'sd1;
          z_m_d    = {1'b0, z_m_q[23:1]};
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        state_d = PACK;
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
        end
      end

      PACK: begin
        state_d = PUT_Z;
        z_d     = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
        if ((z_e_q == E_MIN) && !z_m_q[23]) z_d[30:23] = 8'd0;
        if (z_e_q > E_MAX)                  z_d = {z_s_q, 8'hFF, 23'd0};
      end

      PUT_Z: begin
        z_stb_d = 1'b1;
        if (z_stb_q && bus_io.output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end

      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GET_A;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      z_q      <= 32'd0;
      a_m_q    <= 27'd0;
      b_m_q    <= 27'd0;
      z_m_q    <= 24'd0;
      a_e_q    <= 10'sd0;
      b_e_q    <= 10'sd0;
      z_e_q    <= 10'sd0;
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      z_s_q    <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      sum_q    <= 28'd0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      z_q      <= z_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      z_m_q    <= z_m_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      z_e_q    <= z_e_d;
      a_s_q    <= a_s_d;
      b_s_q    <= b_s_d;
      z_s_q    <= z_s_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      z_stb_q  <= z_stb_d;
    end
  end

endmodule

`default_nettype wire
